// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the 8N1 UART: register offsets, frame geometry and FSM states.
package uart_fifo_pkg;

  localparam logic [2:0] UART_DATA  = 3'd0;
  localparam logic [2:0] UART_RXPOP = 3'd1;
  localparam logic [2:0] UART_TXRDY = 3'd2;
  localparam logic [2:0] UART_STAT  = 3'd3;
  localparam logic [2:0] UART_IRQEN = 3'd4;
  localparam logic [2:0] UART_DIV   = 3'd5;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = FRAME_BITS - 2;
  localparam logic [15:0] DIV_MIN = 16'd4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divisors below DIV_MIN would leave no room for the mid-bit sample point.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

endpackage

// File: rtl/quasi_sync_fifo.sv
// Synchronous FIFO with combinational head output; simultaneous push/pop keeps the count.
module quasi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_fifo.sv
// MMIO UART with 8N1 TX/RX, runtime baud divisor, TX/RX FIFOs, sticky error flags and IRQ.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic        rxnew,
  output logic [7:0]  rxdata
);

  localparam logic [15:0] DIV_RST  = 16'(CLK_HZ / BAUD);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic [15:0] div_q, div_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        frame_err_q, frame_err_d, overrun_q, overrun_d, irq_q, irq_d;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic        tx_q, tx_d, tx_pop, tx_push, tx_tick;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rxdata_q, rxdata_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rxnew_q, rxnew_d;
  logic        rx_push, rx_pop, rx_tick, rx_half, frame_err_set, overrun_set;

  logic [7:0]  tx_head, rx_head;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic [$clog2(TX_DEPTH):0] tx_count_unused;
  logic [$clog2(RX_DEPTH):0] rx_count_unused;
  logic        unused_bits;

  quasi_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .din(d[31:24]), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count_unused)
  );

  quasi_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_shift_q), .pop(rx_pop),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_count_unused)
  );

  assign unused_bits = &{1'b0, d[23:16], tx_count_unused, rx_count_unused};
  assign tx_push = we && (a == UART_DATA);
  assign rx_pop  = we && (a == UART_RXPOP);
  assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);
  assign rx_tick = (rx_cnt_q == rx_div_q - 16'd1);
  assign rx_half = (rx_cnt_q == (rx_div_q >> 1) - 16'd1);

  always_comb begin
    div_d       = div_q;
    irq_en_d    = irq_en_q;
    if (we && a == UART_DIV)   div_d    = clamp_div(d[15:0]);
    if (we && a == UART_IRQEN) irq_en_d = d[25:24];
    // Setting a flag wins over a clear landing in the same cycle.
    frame_err_d = (frame_err_q & ~(we && a == UART_STAT && d[31])) | frame_err_set;
    overrun_d   = (overrun_q   & ~(we && a == UART_STAT && d[30])) | overrun_set;
    irq_d       = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_head; tx_div_d = div_q;
          tx_state_d = TX_START; tx_d = 1'b0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_cnt_d = '0; tx_bit_d = '0; tx_d = tx_shift_q[0];
        tx_shift_d = tx_shift_q >> 1; tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_d = '0;
        if (tx_bit_q == LAST_BIT) begin
          tx_state_d = TX_STOP; tx_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1; tx_d = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TX_STOP: if (tx_tick) begin
        tx_cnt_d = '0;
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_shift_d = tx_head; tx_div_d = div_q;
          tx_state_d = TX_START; tx_d = 1'b0;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q + 16'd1;
    rx_div_d      = rx_div_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rxnew_d       = 1'b0;
    rxdata_d      = rxdata_q;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    overrun_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        // Edge detection also keeps a stuck-low line after a framing error from re-arming.
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START; rx_div_d = div_q;
        end
      end
      RX_START: if (rx_half) begin
        rx_cnt_d = '0; rx_bit_d = '0;
        rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_d = '0; rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
        else                      rx_bit_d   = rx_bit_q + 3'd1;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_d = '0; rx_state_d = RX_IDLE;
        if (rx_s2_q) begin
          rxnew_d = 1'b1; rxdata_d = rx_shift_q;
          if (rx_full) overrun_set = 1'b1;
          else         rx_push     = 1'b1;
        end else begin
          frame_err_set = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    case (a)
      UART_DATA:  spo = rx_empty ? 32'd0 : {rx_head, 24'd0};
      UART_RXPOP: spo = {7'd0, ~rx_empty, 24'd0};
      UART_TXRDY: spo = {7'd0, ~tx_full, 24'd0};
      UART_STAT:  spo = {frame_err_q, overrun_q, tx_empty, tx_full, rx_full, rx_empty, 2'd0, 24'd0};
      UART_IRQEN: spo = {6'd0, irq_en_q, 24'd0};
      UART_DIV:   spo = {16'd0, div_q};
      default:    spo = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= DIV_RST; irq_en_q <= '0; frame_err_q <= 1'b0; overrun_q <= 1'b0; irq_q <= 1'b0;
      tx_state_q <= TX_IDLE; tx_cnt_q <= '0; tx_div_q <= DIV_RST; tx_bit_q <= '0;
      tx_shift_q <= '0; tx_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_cnt_q <= '0; rx_div_q <= DIV_RST; rx_bit_q <= '0;
      rx_shift_q <= '0; rxnew_q <= 1'b0; rxdata_q <= '0;
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
    end else begin
      div_q <= div_d; irq_en_q <= irq_en_d; frame_err_q <= frame_err_d;
      overrun_q <= overrun_d; irq_q <= irq_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d; tx_shift_q <= tx_shift_d; tx_q <= tx_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d; rxnew_q <= rxnew_d; rxdata_q <= rxdata_d;
      rx_s1_q <= rx; rx_s2_q <= rx_s1_q; rx_prev_q <= rx_s2_q;
    end
  end

  assign tx     = tx_q;
  assign irq    = irq_q;
  assign rxnew  = rxnew_q;
  assign rxdata = rxdata_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: TX waveform, loopback RX, FIFO limits, error flags, IRQ, reset.
module tb_uart_fifo;

  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam logic [31:0] DIV_RST = 32'd434;

  logic        clk = 1'b0, rst_n = 1'b0, rx_drv = 1'b1, loop_en = 1'b0, we = 1'b0;
  logic [2:0]  a = 3'd0;
  logic [31:0] d = 32'd0;
  logic        rx_in, tx, irq, rxnew, seen;
  logic [31:0] spo;
  logic [7:0]  rxdata;
  int          check_count = 0, error_count = 0, rxnew_count = 0, rxnew_before;

  assign rx_in = loop_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx_in), .tx(tx), .a(a), .d(d), .we(we),
    .spo(spo), .irq(irq), .rxnew(rxnew), .rxdata(rxdata)
  );

  always @(negedge clk) if (rxnew) rxnew_count++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
    a = addr; d = data; we = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [2:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    checkOutput(tag, spo, exp);
    tick(1);
  endtask

  task automatic waitRxnew(input int budget, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick(1);
      if (rxnew) hit = 1'b1;
    end
  endtask

  task automatic sendRxFrame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0; tick(8);
    for (int i = 0; i < 8; i++) begin rx_drv = b[i]; tick(8); end
    rx_drv = stop_bit; tick(8);
    rx_drv = 1'b1; tick(8);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] byte_v;
    logic       exp_bit;

    // Reset state
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checkOutput("rst_tx", 32'(tx), 32'd1);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("rst_rxnew", 32'(rxnew), 32'd0);
    checkOutput("rst_rxdata", 32'(rxdata), 32'd0);
    readCheck("rst_data", 3'd0, 32'h0000_0000);
    readCheck("rst_rxpop", 3'd1, 32'h0000_0000);
    readCheck("rst_txrdy", 3'd2, 32'h0100_0000);
    readCheck("rst_stat", 3'd3, 32'h2400_0000);
    readCheck("rst_irqen", 3'd4, 32'h0000_0000);
    readCheck("rst_div", 3'd5, DIV_RST);
    readCheck("rst_r6", 3'd6, 32'h0000_0000);

    // Test 1: single 0x55 frame at div=8
    applyStimulus(3'd5, 32'd8);
    readCheck("t1_div", 3'd5, 32'd8);
    applyStimulus(3'd0, 32'h5500_0000);
    checkOutput("t1_tx_before", 32'(tx), 32'd1);
    tick(1);
    byte_v = 8'h55;
    for (int i = 0; i < 80; i++) begin
      if (i / 8 == 0)      exp_bit = 1'b0;
      else if (i / 8 == 9) exp_bit = 1'b1;
      else                 exp_bit = byte_v[i / 8 - 1];
      if (i % 8 == 0 || i % 8 == 7)
        checkOutput($sformatf("t1_bit%0d_c%0d", i / 8, i % 8), 32'(tx), 32'(exp_bit));
      tick(1);
    end
    checkOutput("t1_tx_after", 32'(tx), 32'd1);
    readCheck("t1_stat", 3'd3, 32'h2400_0000);

    // Test 2: loopback of two back-to-back bytes
    loop_en = 1'b1;
    applyStimulus(3'd0, 32'hA500_0000);
    applyStimulus(3'd0, 32'h3C00_0000);
    waitRxnew(200, seen);
    checkOutput("t2_rxnew1", 32'(seen), 32'd1);
    checkOutput("t2_rxdata1", 32'(rxdata), 32'hA5);
    waitRxnew(200, seen);
    checkOutput("t2_rxnew2", 32'(seen), 32'd1);
    checkOutput("t2_rxdata2", 32'(rxdata), 32'h3C);
    readCheck("t2_head1", 3'd0, 32'hA500_0000);
    applyStimulus(3'd1, 32'd0);
    readCheck("t2_head2", 3'd0, 32'h3C00_0000);
    applyStimulus(3'd1, 32'd0);
    readCheck("t2_rxpop_empty", 3'd1, 32'h0000_0000);

    // Test 3: TX overfill, extra byte dropped
    for (int k = 0; k < TXD + 2; k++) applyStimulus(3'd0, {8'(8'h10 + k), 24'd0});
    readCheck("t3_txrdy_full", 3'd2, 32'h0000_0000);
    readCheck("t3_stat_full", 3'd3, 32'h1400_0000);
    for (int k = 0; k < TXD + 1; k++) begin
      waitRxnew(200, seen);
      checkOutput($sformatf("t3_frame%0d_seen", k), 32'(seen), 32'd1);
      checkOutput($sformatf("t3_frame%0d_data", k), 32'(rxdata), 32'(8'h10 + k));
      applyStimulus(3'd1, 32'd0);
    end
    waitRxnew(200, seen);
    checkOutput("t3_no_extra", 32'(seen), 32'd0);

    // Test 4: RX overrun
    for (int k = 0; k < RXD + 1; k++) applyStimulus(3'd0, {8'(8'h20 + k), 24'd0});
    for (int k = 0; k < RXD + 1; k++) begin
      waitRxnew(200, seen);
      checkOutput($sformatf("t4_frame%0d_seen", k), 32'(seen), 32'd1);
    end
    checkOutput("t4_rxdata_last", 32'(rxdata), 32'h24);
    readCheck("t4_stat_overrun", 3'd3, 32'h6800_0000);
    applyStimulus(3'd3, 32'h4000_0000);
    readCheck("t4_stat_cleared", 3'd3, 32'h2800_0000);
    for (int k = 0; k < RXD; k++) begin
      readCheck($sformatf("t4_head%0d", k), 3'd0, {8'(8'h20 + k), 24'd0});
      applyStimulus(3'd1, 32'd0);
    end
    readCheck("t4_rx_drained", 3'd1, 32'h0000_0000);

    // Test 5: framing error, then a short glitch
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    tick(4);
    rxnew_before = rxnew_count;
    sendRxFrame(8'hC3, 1'b0);
    tick(4);
    checkOutput("t5_no_rxnew", 32'(rxnew_count), 32'(rxnew_before));
    readCheck("t5_stat_ferr", 3'd3, 32'hA400_0000);
    applyStimulus(3'd3, 32'h8000_0000);
    readCheck("t5_stat_clear", 3'd3, 32'h2400_0000);
    rx_drv = 1'b0; tick(1); rx_drv = 1'b1;
    tick(40);
    checkOutput("t5_glitch_rxnew", 32'(rxnew_count), 32'(rxnew_before));
    readCheck("t5_glitch_stat", 3'd3, 32'h2400_0000);

    // Test 6: RX irq, div clamp, reset mid-frame
    applyStimulus(3'd4, 32'h0100_0000);
    readCheck("t6_irqen", 3'd4, 32'h0100_0000);
    checkOutput("t6_irq_idle", 32'(irq), 32'd0);
    sendRxFrame(8'h5A, 1'b1);
    tick(2);
    checkOutput("t6_irq_set", 32'(irq), 32'd1);
    checkOutput("t6_rxdata", 32'(rxdata), 32'h5A);
    applyStimulus(3'd1, 32'd0);
    tick(1);
    checkOutput("t6_irq_clear", 32'(irq), 32'd0);
    applyStimulus(3'd5, 32'd2);
    readCheck("t6_div_clamp", 3'd5, 32'd4);
    applyStimulus(3'd5, 32'd8);
    applyStimulus(3'd0, 32'h9900_0000);
    tick(20);
    checkOutput("t6_tx_mid", 32'(tx), 32'd0);
    rst_n = 1'b0;
    tick(1);
    checkOutput("t6_rst_tx", 32'(tx), 32'd1);
    checkOutput("t6_rst_irq", 32'(irq), 32'd0);
    checkOutput("t6_rst_rxdata", 32'(rxdata), 32'd0);
    readCheck("t6_rst_data", 3'd0, 32'h0000_0000);
    readCheck("t6_rst_stat", 3'd3, 32'h2400_0000);
    readCheck("t6_rst_irqen", 3'd4, 32'h0000_0000);
    readCheck("t6_rst_div", 3'd5, DIV_RST);
    rst_n = 1'b1;
    tick(2);
    checkOutput("t6_tx_after_rst", 32'(tx), 32'd1);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
